sid_filter_chain: RTL and testbench



---
 rtl/sid_filter_chain_if.sv | 27 ++
 rtl/sid_filter_chain.sv | 144 ++++++++++++++
 tb/tb_sid_filter_chain.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sid_filter_chain_if.sv
// SID analog back-end bus: sample strobe, register port, audio in/out.
// The producer side (voice mixers / register file) is the master.
interface sid_filter_chain_if;
  logic               clkEn;
  logic               iWE;
  logic        [4:0]  iAddr;
  logic        [7:0]  iDataW;
  logic signed [15:0] iIn;
  logic signed [15:0] iBypass;
  logic        [2:0]  iMode;
  logic signed [15:0] oLP;
  logic signed [15:0] oBP;
  logic signed [15:0] oHP;
  logic signed [15:0] oOut;

  modport master (
    output clkEn, iWE, iAddr, iDataW,
    output iIn, iBypass, iMode,
    input  oLP, oBP, oHP, oOut
  );

  modport slave (
    input  clkEn, iWE, iAddr, iDataW,
    input  iIn, iBypass, iMode,
    output oLP, oBP, oHP, oOut
  );
endinterface

// File: rtl/sid_filter_chain.sv
// SID analog back-end: Chamberlin state-variable filter, saturating
// post-filter mixer and a k=3/32 one-pole output smoother.
module sid_filter_chain (
  input  logic              clk,
  input  logic              rst,
  sid_filter_chain_if.slave bus
);

  logic        [10:0] r_cutoff;
  logic        [3:0]  r_res;
  logic signed [15:0] r_lp;
  logic signed [15:0] r_bp;
  logic signed [15:0] r_hp;
  logic signed [15:0] r_mix;
  logic signed [20:0] r_acc;

  logic        [12:0] w_f;
  logic        [12:0] w_d;
  logic signed [31:0] w_fs;
  logic signed [31:0] w_ds;
  logic signed [31:0] w_fbp;
  logic signed [31:0] w_dbp;
  logic signed [31:0] w_fhp;
  logic signed [31:0] w_lp_s;
  logic signed [31:0] w_hp_s;
  logic signed [31:0] w_bp_s;
  logic signed [15:0] w_lp;
  logic signed [15:0] w_hp;
  logic signed [15:0] w_bp;
  logic signed [17:0] w_sum;
  logic signed [15:0] w_clip;
  logic signed [31:0] w_tgt;
  logic signed [31:0] w_accx;
  logic signed [31:0] w_diff;
  logic signed [31:0] w_step;
  logic signed [31:0] w_acc_n;

  function automatic logic signed [31:0] sx32(
    input logic signed [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic signed [17:0] sx18(
    input logic signed [15:0] v
  );
    return {{2{v[15]}}, v};
  endfunction

  function automatic logic signed [15:0] sat16(
    input logic signed [31:0] v
  );
    if (v > 32'sd32767)
      return 16'sh7fff;
    else if (v < -32'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  // f = 2.5*cutoff + 12 (Q0.16), d = 5792 - 340*res (Q4.12)
  assign w_f = {1'b0, r_cutoff, 1'b0}
             + {3'b000, r_cutoff[10:1]}
             + 13'd12;
  assign w_d = 13'd5792 - ({9'd0, r_res} * 13'd340);

  assign w_fs = $signed({19'd0, w_f});
  assign w_ds = $signed({19'd0, w_d});

  assign w_fbp  = w_fs * sx32(r_bp);
  assign w_dbp  = w_ds * sx32(r_bp);
  assign w_lp_s = sx32(r_lp) + (w_fbp >>> 16);
  assign w_lp   = sat16(w_lp_s);

  assign w_hp_s = sx32(bus.iIn)
                - sx32(w_lp)
                - (w_dbp >>> 12);
  assign w_hp   = sat16(w_hp_s);

  // bp integrates the freshly computed hp, not the old one
  assign w_fhp  = w_fs * sx32(w_hp);
  assign w_bp_s = sx32(r_bp) + (w_fhp >>> 16);
  assign w_bp   = sat16(w_bp_s);

  assign w_sum = sx18(bus.iBypass)
               + (bus.iMode[0] ? sx18(r_lp) : 18'sd0)
               + (bus.iMode[1] ? sx18(r_bp) : 18'sd0)
               + (bus.iMode[2] ? sx18(r_hp) : 18'sd0);

  always_comb begin
    w_clip = w_sum[15:0];
    if (w_sum > 18'sd32767)
      w_clip = 16'sh7fff;
    else if (w_sum < -18'sd32768)
      w_clip = 16'sh8000;
  end

  assign w_tgt   = $signed({{11{r_mix[15]}}, r_mix, 5'd0});
  assign w_accx  = $signed({{11{r_acc[20]}}, r_acc});
  assign w_diff  = w_tgt - w_accx;
  assign w_step  = (w_diff * 32'sd3) >>> 5;
  assign w_acc_n = w_accx + w_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cutoff <= '0;
      r_res    <= '0;
    end else if (bus.iWE) begin
      case (bus.iAddr)
        5'h15:   r_cutoff[2:0]  <= bus.iDataW[2:0];
        5'h16:   r_cutoff[10:3] <= bus.iDataW;
        5'h17:   r_res          <= bus.iDataW[7:4];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lp  <= '0;
      r_bp  <= '0;
      r_hp  <= '0;
      r_acc <= '0;
    end else if (bus.clkEn) begin
      r_lp  <= w_lp;
      r_bp  <= w_bp;
      r_hp  <= w_hp;
      r_acc <= 21'(w_acc_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_mix <= '0;
    else
      r_mix <= w_clip;
  end

  assign bus.oLP  = r_lp;
  assign bus.oBP  = r_bp;
  assign bus.oHP  = r_hp;
  assign bus.oOut = r_acc[20:5];

endmodule

// File: tb/tb_sid_filter_chain.sv
// Bench for sid_filter_chain: random stimulus against an integer model
// of the filter/mixer/smoother equations, plus hand-computed pins.
module tb_sid_filter_chain;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sid_filter_chain_if bus();

  sid_filter_chain dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit seen_rst = 0;

  int m_cut, m_res, m_lp, m_bp, m_hp, m_mix, m_acc;
  int nlp, nbp, nhp, nmix, nacc, f, d, s;

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d, want %0d @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string nm, input int act,
                           input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Reference model: evaluates the equations once per clock edge
  always begin
    @(posedge clk);
    if (rst) begin
      m_cut = 0; m_res = 0;
      m_lp = 0; m_bp = 0; m_hp = 0;
      m_mix = 0; m_acc = 0;
      seen_rst = 1;
    end else begin
      nlp = m_lp; nbp = m_bp; nhp = m_hp; nacc = m_acc;
      if (bus.clkEn) begin
        f    = 2 * m_cut + m_cut / 2 + 12;
        d    = 5792 - 340 * m_res;
        nlp  = sat(m_lp + ((f * m_bp) >>> 16));
        nhp  = sat(int'(bus.iIn) - nlp - ((d * m_bp) >>> 12));
        nbp  = sat(m_bp + ((f * nhp) >>> 16));
        nacc = m_acc + ((((m_mix * 32) - m_acc) * 3) >>> 5);
      end
      s = int'(bus.iBypass)
        + (bus.iMode[0] ? m_lp : 0)
        + (bus.iMode[1] ? m_bp : 0)
        + (bus.iMode[2] ? m_hp : 0);
      nmix = sat(s);
      if (bus.iWE) begin
        case (bus.iAddr)
          5'h15: m_cut = (m_cut & 'h7f8) | int'(bus.iDataW[2:0]);
          5'h16: m_cut = (m_cut & 7) | (int'(bus.iDataW) << 3);
          5'h17: m_res = int'(bus.iDataW) >> 4;
          default: ;
        endcase
      end
      m_lp = nlp; m_bp = nbp; m_hp = nhp;
      m_mix = nmix; m_acc = nacc;
    end
    #1;
    if (seen_rst) begin
      check("oLP",  int'(bus.oLP),  m_lp);
      check("oBP",  int'(bus.oBP),  m_bp);
      check("oHP",  int'(bus.oHP),  m_hp);
      check("oOut", int'(bus.oOut), m_acc >>> 5);
    end
  end

  task automatic clear_in();
    bus.clkEn   = 0;
    bus.iWE     = 0;
    bus.iAddr   = '0;
    bus.iDataW  = '0;
    bus.iIn     = '0;
    bus.iBypass = '0;
    bus.iMode   = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    clear_in();
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] v);
    bus.iWE = 1; bus.iAddr = a; bus.iDataW = v;
    @(negedge clk);
    bus.iWE = 0;
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      bus.clkEn = 1;
      @(negedge clk);
      bus.clkEn = 0;
      @(negedge clk);
    end
  endtask

  initial begin
    clear_in();
    do_reset();

    // Randomised run, resonance and rails included
    for (int i = 0; i < 1500; i++) begin
      bus.clkEn  = ($urandom_range(0, 2) == 0);
      bus.iWE    = ($urandom_range(0, 5) == 0);
      bus.iAddr  = 5'($urandom_range(5'h14, 5'h18));
      bus.iDataW = 8'($urandom);
      if ($urandom_range(0, 7) == 0)
        bus.iIn = ($urandom_range(0, 3) == 0)
                ? ($urandom_range(0, 1) ? 16'sh7fff : 16'sh8000)
                : 16'($urandom);
      if ($urandom_range(0, 7) == 0)
        bus.iBypass = 16'($urandom);
      if ($urandom_range(0, 15) == 0)
        bus.iMode = 3'($urandom);
      @(negedge clk);
    end

    // Reset with live inputs and a pending write
    bus.iIn = 16'sd12345; bus.iBypass = -16'sd777; bus.iMode = 3'b111;
    bus.iWE = 1; bus.iAddr = 5'h16; bus.iDataW = 8'hAA; bus.clkEn = 1;
    rst = 1;
    repeat (2) @(negedge clk);
    check("rst oLP",  int'(bus.oLP),  0);
    check("rst oBP",  int'(bus.oBP),  0);
    check("rst oHP",  int'(bus.oHP),  0);
    check("rst oOut", int'(bus.oOut), 0);
    rst = 0;
    clear_in();
    pulse(3);
    check("post-rst oLP",  int'(bus.oLP),  0);
    check("post-rst oOut", int'(bus.oOut), 0);

    // Register decode and first step: f = 5129, d = 5792
    wr(5'h16, 8'hFF);
    wr(5'h15, 8'h07);
    wr(5'h17, 8'h00);
    bus.iIn = 16'sd16384;
    pulse(1);
    check("step1 oLP", int'(bus.oLP), 0);
    check("step1 oHP", int'(bus.oHP), 16384);
    check("step1 oBP", int'(bus.oBP), 1282);

    // Smoother from zero: 32000*32*3/32 = 96000 -> 3000
    do_reset();
    bus.iBypass = 16'sd32000;
    @(negedge clk);
    pulse(1);
    check("smooth 1st", int'(bus.oOut), 3000);
    pulse(200);
    check_rng("smooth settle", int'(bus.oOut), 31999, 32000);

    // Clipper at both rails
    do_reset();
    wr(5'h16, 8'hFF);
    wr(5'h15, 8'h07);
    bus.iBypass = 16'sd20000; bus.iIn = 16'sd20000; bus.iMode = 3'b001;
    pulse(400);
    check_rng("clip hi", int'(bus.oOut), 32766, 32767);
    bus.iBypass = -16'sd20000; bus.iIn = -16'sd20000;
    pulse(400);
    check("clip lo", int'(bus.oOut), -32768);

    // DC: f = 2572, d = 3072; truncation may park lp a few LSB below
    do_reset();
    wr(5'h16, 8'h80);
    wr(5'h15, 8'h00);
    wr(5'h17, 8'h80);
    bus.iIn = -16'sd10000;
    pulse(5000);
    check_rng("dc oLP", int'(bus.oLP), -10048, -9996);
    check_rng("dc oBP", int'(bus.oBP), -32, 32);
    check_rng("dc oHP", int'(bus.oHP), -32, 32);

    // Write and clkEn on one edge: old f=12, then f=5112
    do_reset();
    bus.iIn = 16'sd16384;
    bus.iWE = 1; bus.iAddr = 5'h16; bus.iDataW = 8'hFF;
    bus.clkEn = 1;
    @(negedge clk);
    bus.iWE = 0; bus.clkEn = 0;
    check("coll oBP", int'(bus.oBP), 3);
    check("coll oHP", int'(bus.oHP), 16384);
    pulse(1);
    check("coll2 oBP", int'(bus.oBP), 1280);
    check("coll2 oHP", int'(bus.oHP), 16380);
    check("coll2 oLP", int'(bus.oLP), 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
